// File: rtl/jk_bank_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver_pkg
// Description : Shared constants for the JK bank driver: 3-bit controller
//               state encoding and request mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_bank_driver_pkg;

    // Controller state encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_check  = 3'd1;
    localparam logic [2:0] c_st_drive  = 3'd2;
    localparam logic [2:0] c_st_settle = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    // Request modes
    localparam logic c_mode_count  = 1'b0;
    localparam logic c_mode_direct = 1'b1;

endpackage : jk_bank_driver_pkg
`default_nettype wire

// File: rtl/jk_bank_driver_inc_mask.sv
`default_nettype none
// ============================================================================
// Module      : jk_inc_mask
// Description : Combinational toggle mask for incrementing a JK bank by one.
//               Bit i is set iff every lower bit of q is 1 (bit 0 always set),
//               so driving J=K=mask toggles exactly the bits an increment
//               changes. An all-ones word yields an all-ones mask (wrap to 0).
// Revision    : 1.0 - initial release
// Ports       : q    in  N  current bank word
//               mask out N  toggle mask
// ============================================================================
module jk_inc_mask #(
    parameter int N = 4
) (
    input  logic [N-1:0] q,
    output logic [N-1:0] mask
);

    logic [N-1:0] w_carry;
    // The MSB never feeds a higher carry; keep it named so it is visibly dropped.
    logic         w_unused_msb;

    assign w_carry[0]   = 1'b1;
    assign w_unused_msb = q[N-1];

    // Prefix-AND ripple: carry into bit i is the AND of all bits below it.
    for (genvar gi = 1; gi < N; gi++) begin : g_chain
        assign w_carry[gi] = w_carry[gi-1] & q[gi-1];
    end

    assign mask = w_carry;

endmodule : jk_inc_mask
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_driver
// Description : Drives the J/K inputs of a bank of N JK flip-flops until the
//               bank word equals a requested target. A request is accepted
//               with an rfd/dav_ handshake, then the bank is either counted
//               up one step per drive (COUNT) or loaded in one shot (DIRECT).
//               Each drive is CHECK -> DRIVE -> SETTLE, so J/K are asserted
//               for exactly one cycle and the bank holds otherwise.
// Revision    : 1.0 - initial release
// Ports       : clock  in   1    system clock (posedge)
//               reset_ in   1    asynchronous active-low reset
//               dav_   in   1    request valid while low
//               target in   N    requested bank value (sampled with dav_)
//               mode   in   1    0 = COUNT, 1 = DIRECT
//               q      in   N    bank outputs (feedback)
//               rfd    out  1    ready for data (IDLE only)
//               j      out  N    J drive, registered
//               k      out  N    K drive, registered
//               done   out  1    request completed, held until dav_ high
//               err    out  1    finished without a match (step limit)
//               steps  out  N+1  drive cycles issued for this request
// ============================================================================
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         dav_,
    input  logic [N-1:0] target,
    input  logic         mode,
    input  logic [N-1:0] q,
    output logic         rfd,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         done,
    output logic         err,
    output logic [N:0]   steps
);

    // 2^N drives is enough to visit every bank value in COUNT mode; hitting
    // it without a match means the bank is not following its drive.
    localparam logic [N:0] c_step_limit = {1'b1, {N{1'b0}}};
    localparam logic [N:0] c_step_one   = {{N{1'b0}}, 1'b1};

    logic [2:0]   r_state,  w_state_nxt;
    logic [N-1:0] r_target, w_target_nxt;
    logic         r_mode,   w_mode_nxt;
    logic [N:0]   r_steps,  w_steps_nxt;
    logic [N-1:0] r_j,      w_j_nxt;
    logic [N-1:0] r_k,      w_k_nxt;
    logic         r_rfd,    w_rfd_nxt;
    logic         r_done,   w_done_nxt;
    logic         r_err,    w_err_nxt;
    logic [N-1:0] w_mask;

    jk_inc_mask #(
        .N    (N)
    ) u_inc_mask (
        .q    (q),
        .mask (w_mask)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_mode_nxt   = r_mode;
        w_steps_nxt  = r_steps;
        w_rfd_nxt    = r_rfd;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        // J/K default to hold; only the CHECK->DRIVE transition loads them.
        w_j_nxt      = '0;
        w_k_nxt      = '0;

        unique case (r_state)
            c_st_idle: begin
                if (!dav_) begin
                    w_target_nxt = target;
                    w_mode_nxt   = mode;
                    w_steps_nxt  = '0;
                    w_rfd_nxt    = 1'b0;
                    w_state_nxt  = c_st_check;
                end
            end

            c_st_check: begin
                if (q == r_target) begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = c_st_done;
                end else if (r_steps == c_step_limit) begin
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_st_done;
                end else begin
                    if (r_mode == c_mode_direct) begin
                        w_j_nxt = r_target;
                        w_k_nxt = ~r_target;
                    end else begin
                        w_j_nxt = w_mask;
                        w_k_nxt = w_mask;
                    end
                    w_steps_nxt = r_steps + c_step_one;
                    w_state_nxt = c_st_drive;
                end
            end

            // Bank samples J/K at the edge ending this state.
            c_st_drive: begin
                w_state_nxt = c_st_settle;
            end

            c_st_settle: begin
                w_state_nxt = c_st_check;
            end

            // A request only completes once dav_ is released, so a held
            // dav_ cannot retrigger.
            c_st_done: begin
                if (dav_) begin
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_rfd_nxt   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end

            default: begin
                w_done_nxt  = 1'b0;
                w_err_nxt   = 1'b0;
                w_rfd_nxt   = 1'b1;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state  <= c_st_idle;
            r_target <= '0;
            r_mode   <= c_mode_count;
            r_steps  <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_rfd    <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_mode   <= w_mode_nxt;
            r_steps  <= w_steps_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_rfd    <= w_rfd_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign rfd   = r_rfd;
    assign j     = r_j;
    assign k     = r_k;
    assign done  = r_done;
    assign err   = r_err;
    assign steps = r_steps;

endmodule : jk_bank_driver
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_driver
// Description : Directed self-checking bench for jk_bank_driver (N=4) with a
//               behavioural bank of 4 JK flip-flops wired to j/k/q. The bank
//               has a preload path used to set the starting word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_driver;

    localparam int N = 4;

    logic         clock  = 1'b0;
    logic         reset_ = 1'b0;
    logic         dav_   = 1'b1;
    logic [N-1:0] target = '0;
    logic         mode   = 1'b0;
    logic [N-1:0] q;
    logic         rfd;
    logic [N-1:0] j;
    logic [N-1:0] k;
    logic         done;
    logic         err;
    logic [N:0]   steps;

    logic         pre_en  = 1'b0;
    logic [N-1:0] pre_val = '0;

    int total = 0;
    int bad   = 0;
    int edges;
    logic [N-1:0] jq[$];
    logic [N-1:0] kq[$];

    always #5 clock = ~clock;

    jk_bank_driver #(
        .N      (N)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .dav_   (dav_),
        .target (target),
        .mode   (mode),
        .q      (q),
        .rfd    (rfd),
        .j      (j),
        .k      (k),
        .done   (done),
        .err    (err),
        .steps  (steps)
    );

    // Bank of JK cells sharing the controller reset.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            q <= '0;
        end else if (pre_en) begin
            q <= pre_val;
        end else begin
            for (int i = 0; i < N; i++) begin
                case ({j[i], k[i]})
                    2'b10:   q[i] <= 1'b1;
                    2'b01:   q[i] <= 1'b0;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Preload the bank, issue a request and wait for done, logging every
    // non-zero J/K drive. edges counts posedges after the dav_ sampling edge.
    task automatic run_req(input logic [N-1:0] q0, input logic [N-1:0] tgt,
                           input logic md, output int n);
        jq.delete();
        kq.delete();
        pre_en  = 1'b1;
        pre_val = q0;
        tick();
        pre_en = 1'b0;
        dav_   = 1'b0;
        target = tgt;
        mode   = md;
        tick();
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (j !== '0 || k !== '0) begin
                jq.push_back(j);
                kq.push_back(k);
            end
        end
    endtask

    task automatic release_req(input string tag);
        dav_ = 1'b1;
        tick();
        check({tag, "_rfd"}, rfd, 1);
        check({tag, "_done_clr"}, done, 0);
    endtask

    initial begin
        // ---------------- reset state
        #12;
        check("rst_rfd", rfd, 1);
        check("rst_jk", {j, k}, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_steps", steps, 0);
        reset_ = 1'b1;
        tick();
        check("idle_rfd", rfd, 1);

        // ---------------- COUNT 3 -> 6
        run_req(4'd3, 4'd6, 1'b0, edges);
        check("c36_edges", edges, 10);
        check("c36_ndrv", jq.size(), 3);
        check("c36_jmask", {jq[0], jq[1], jq[2]}, 12'h713);
        check("c36_kmask", {kq[0], kq[1], kq[2]}, 12'h713);
        check("c36_q", q, 6);
        check("c36_steps", steps, 3);
        check("c36_err", err, 0);
        // dav_ held low: stays in DONE
        tick();
        tick();
        check("hold_done", done, 1);
        check("hold_rfd", rfd, 0);
        check("hold_jk", {j, k}, 0);
        release_req("c36_rel");

        // ---------------- COUNT wrap 14 -> 1
        run_req(4'd14, 4'd1, 1'b0, edges);
        check("wrap_edges", edges, 10);
        check("wrap_ndrv", jq.size(), 3);
        check("wrap_mask", {jq[0], jq[1], jq[2]}, 12'h1F1);
        check("wrap_q", q, 1);
        check("wrap_steps", steps, 3);
        check("wrap_err", err, 0);
        release_req("wrap_rel");

        // ---------------- DIRECT 0101 -> 1010
        run_req(4'b0101, 4'b1010, 1'b1, edges);
        check("dir_edges", edges, 4);
        check("dir_ndrv", jq.size(), 1);
        check("dir_j", jq[0], 4'b1010);
        check("dir_k", kq[0], 4'b0101);
        check("dir_q", q, 4'b1010);
        check("dir_steps", steps, 1);
        release_req("dir_rel");

        // ---------------- target already equal, both modes
        run_req(4'd9, 4'd9, 1'b0, edges);
        check("eqc_edges", edges, 1);
        check("eqc_ndrv", jq.size(), 0);
        check("eqc_steps", steps, 0);
        check("eqc_err", err, 0);
        release_req("eqc_rel");
        run_req(4'd9, 4'd9, 1'b1, edges);
        check("eqd_edges", edges, 1);
        check("eqd_ndrv", jq.size(), 0);
        check("eqd_steps", steps, 0);
        release_req("eqd_rel");

        // ---------------- step limit: bank pinned at 0 never matches
        pre_en  = 1'b1;
        pre_val = 4'd0;
        dav_    = 1'b0;
        target  = 4'd5;
        mode    = 1'b0;
        tick();
        edges = 0;
        while (!done && edges < 200) begin
            tick();
            edges++;
        end
        check("lim_edges", edges, 49);
        check("lim_err", err, 1);
        check("lim_steps", steps, 16);
        pre_en = 1'b0;
        release_req("lim_rel");
        check("lim_err_clr", err, 0);

        // ---------------- reset mid-COUNT 0 -> 15 after two drives
        pre_en  = 1'b1;
        pre_val = 4'd0;
        tick();
        pre_en = 1'b0;
        dav_   = 1'b0;
        target = 4'd15;
        mode   = 1'b0;
        tick();
        repeat (6) tick();
        check("mid_steps", steps, 2);
        check("mid_q", q, 2);
        #2 reset_ = 1'b0;
        #1;
        check("arst_rfd", rfd, 1);
        check("arst_jk", {j, k}, 0);
        check("arst_done", done, 0);
        check("arst_steps", steps, 0);
        check("arst_q", q, 0);
        dav_ = 1'b1;
        #1 reset_ = 1'b1;
        repeat (3) tick();
        check("post_rfd", rfd, 1);
        check("post_jk", {j, k}, 0);
        check("post_q", q, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_jk_bank_driver
`default_nettype wire
